modn_count_sequencer: RTL and testbench

Synchronous command-driven controller for a programmable-modulus counter (mod 1 to mod 2^WIDTH, default 3-bit, so mod-6 is one setting). A requester issues a command (terminal value, lap count, direction) over a valid/ready handshake. The block runs the counter for that many full wraps, pausing whenever the advance qualifier is low, then signals completion. It replaces free-running ripple counters wherever software or another FSM must start, bound and abort a counting sequence.

---
 rtl/modn_count_sequencer.sv | 100 ++++++++++
 tb/tb_modn_count_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modn_count_sequencer.sv
// Command-driven programmable-modulus counter: runs cmd_laps full wraps of a mod-(term+1) count, then pulses done.
// Latency: q shows the start value at the acceptance edge; each wrap/done is registered from the wrapping edge.
// Backpressure: cmd_ready is high only in IDLE; cnt_en low stalls the count without losing state.
module modn_count_sequencer #(
    parameter int WIDTH = 3,
    parameter int LAPW  = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_term,
    input  logic [LAPW-1:0]  cmd_laps,
    input  logic             cmd_down,
    input  logic             cnt_en,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] QONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LAPW:0]    LAP_ONE  = {{LAPW{1'b0}}, 1'b1};
    localparam logic [LAPW:0]    LAP_FULL = {1'b1, {LAPW{1'b0}}};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] term_r;
    logic             down_r;
    logic [LAPW:0]    laps_r;     // one extra bit so a zero command can hold 2^LAPW
    logic             accept;
    logic             at_end;
    logic             adv;
    logic             last_lap;

    assign accept    = cmd_valid && (state == IDLE);
    assign at_end    = down_r ? (q == '0) : (q == term_r);
    assign adv       = (state == RUN) && cnt_en && !abort;
    assign last_lap  = (laps_r == LAP_ONE);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (abort)
                    state_nxt = IDLE;
                else if (cnt_en && at_end && last_lap)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q      <= '0;
            wrap   <= 1'b0;
            done   <= 1'b0;
            term_r <= '0;
            down_r <= 1'b0;
            laps_r <= '0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            if (accept) begin
                term_r <= cmd_term;
                down_r <= cmd_down;
                laps_r <= (cmd_laps == '0) ? LAP_FULL : {1'b0, cmd_laps};
                q      <= cmd_down ? cmd_term : '0;
            end else if ((state == RUN) && abort) begin
                q      <= '0;
                laps_r <= '0;
            end else if (adv) begin
                if (at_end) begin
                    // reload the start value so q rests there through DONE
                    q      <= down_r ? term_r : '0;
                    wrap   <= 1'b1;
                    laps_r <= laps_r - LAP_ONE;
                    done   <= last_lap;
                end else begin
                    q <= down_r ? (q - QONE) : (q + QONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_modn_count_sequencer.sv
// Bench for modn_count_sequencer: directed scenarios plus random traffic against a behavioural model.
module tb_modn_count_sequencer;

    logic       clk = 1'b0;
    logic       clr, cmd_valid, cmd_ready, cmd_down, cnt_en, abort;
    logic [2:0] cmd_term, q;
    logic [3:0] cmd_laps;
    logic       wrap, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: 0 idle, 1 running, 2 completion cycle
    int mst = 0, mq = 0, mterm = 0, mlaps = 0;
    bit mdown = 0, mwrap = 0;

    always #5 clk = ~clk;

    modn_count_sequencer #(.WIDTH(3), .LAPW(4)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_term(cmd_term), .cmd_laps(cmd_laps), .cmd_down(cmd_down),
        .cnt_en(cnt_en), .abort(abort), .q(q), .wrap(wrap), .busy(busy), .done(done)
    );

    logic [6:0] obs;
    assign obs = {q, wrap, busy, done, cmd_ready};

    function automatic logic [6:0] expv();
        logic [2:0] eq;
        eq = mq[2:0];
        return {eq, mwrap, mst != 0, mst == 2, mst == 0};
    endfunction

    task automatic step(input bit c, input bit v, input int t, input int l,
                        input bit d, input bit e, input bit a);
        clr = c; cmd_valid = v; cmd_term = t[2:0]; cmd_laps = l[3:0];
        cmd_down = d; cnt_en = e; abort = a;
        @(posedge clk);
        mwrap = 0;
        if (c) begin
            mst = 0; mq = 0; mterm = 0; mlaps = 0; mdown = 0;
        end else if (mst == 0) begin
            if (v) begin
                mterm = t % 8; mdown = d;
                mlaps = (l % 16 == 0) ? 16 : l % 16;
                mq = d ? mterm : 0;
                mst = 1;
            end
        end else if (mst == 1) begin
            if (a) begin
                mst = 0; mq = 0; mlaps = 0;
            end else if (e) begin
                if ((!mdown && mq == mterm) || (mdown && mq == 0)) begin
                    mq = mdown ? mterm : 0;
                    mwrap = 1;
                    mlaps = mlaps - 1;
                    if (mlaps == 0) mst = 2;
                end else begin
                    mq = mdown ? mq - 1 : mq + 1;
                end
            end
        end else begin
            mst = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs !== 7'b000_0001) begin
            n_fail++; $display("FAIL reset_idle: got %b want %b", obs, 7'b000_0001);
        end
        step(0, 1, 5, 2, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 5, 2, 0, 1, 0);
        n_checks++;
        if (obs !== 7'b000_0001) begin
            n_fail++; $display("FAIL reset_midrun: got %b want %b", obs, 7'b000_0001);
        end
        step(1, 1, 5, 2, 0, 1, 0);
        n_checks++;
        if (obs !== 7'b000_0001) begin
            n_fail++; $display("FAIL reset_accept_cycle: got %b want %b", obs, 7'b000_0001);
        end
    endtask

    task automatic test_mod6_up();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 1, 0);
        n_checks++;
        if (q !== 3'd0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL up_accept: q=%0d busy=%b rdy=%b want 0 1 0", q, busy, cmd_ready);
        end
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            n_checks++;
            if (q !== 3'(i % 6) || wrap !== (i == 6) || done !== (i == 6)) begin
                n_fail++;
                $display("FAIL up_seq edge %0d: q=%0d wrap=%b done=%b want %0d %b %b",
                         i, q, wrap, done, i % 6, i == 6, i == 6);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || wrap !== 1'b0) begin
            n_fail++; $display("FAIL up_return: rdy=%b busy=%b done=%b wrap=%b want 1 0 0 0",
                               cmd_ready, busy, done, wrap);
        end
    endtask

    task automatic test_mod6_down_toggle();
        int nwraps = 0, done_edge = -1, prevq;
        bit en;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 3, 1, 0, 0);
        prevq = q;
        for (int k = 1; k <= 60 && done_edge < 0; k++) begin
            en = (k % 2 == 0);
            step(0, 0, 3, 9, 0, en, 0);   // changing command fields must not matter
            n_checks++;
            if (obs !== expv() || (!en && q !== 3'(prevq))) begin
                n_fail++; $display("FAIL down_step %0d: got %b want %b", k, obs, expv());
            end
            if (wrap) nwraps++;
            if (done) done_edge = k;
            prevq = q;
        end
        n_checks++;
        if (nwraps != 3 || done_edge != 36) begin
            n_fail++; $display("FAIL down_totals: wraps=%0d final_edge=%0d want 3 36", nwraps, done_edge);
        end
    endtask

    task automatic test_abort();
        int nw = 0;
        bit hit = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 4, 0, 1, 0);
        for (int k = 0; k < 40 && !hit; k++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            if (wrap) nw++;
            if (nw == 1 && q == 3'd3) hit = 1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++; $display("FAIL abort_reach: lap2 q=3 not reached, q=%0d wraps=%0d", q, nw);
        end
        step(0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (obs !== 7'b000_0001) begin
            n_fail++; $display("FAIL abort_effect: got %b want %b", obs, 7'b000_0001);
        end
        step(0, 1, 2, 1, 1, 1, 0);
        n_checks++;
        if (busy !== 1'b1 || q !== 3'd2) begin
            n_fail++; $display("FAIL abort_reaccept: busy=%b q=%0d want 1 2", busy, q);
        end
    endtask

    task automatic test_term0();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            n_checks++;
            if (q !== 3'd0 || wrap !== 1'b1 || done !== (i == 16)) begin
                n_fail++; $display("FAIL term0 edge %0d: q=%0d wrap=%b done=%b want 0 1 %b",
                                   i, q, wrap, done, i == 16);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (wrap !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL term0_end: wrap=%b done=%b rdy=%b want 0 0 1", wrap, done, cmd_ready);
        end
    endtask

    task automatic test_term7();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 1, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            n_checks++;
            if (q !== 3'(i % 8) || wrap !== (i == 8)) begin
                n_fail++; $display("FAIL term7 edge %0d: q=%0d wrap=%b want %0d %b", i, q, wrap, i % 8, i == 8);
            end
        end
    endtask

    task automatic test_hold_valid();
        int accepts = 0;
        bit was_busy = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 1, 1, 0, 1, 0);
            if (busy && !was_busy) accepts++;
            was_busy = busy;
            n_checks++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL hold_valid cyc %0d: got %b want %b", i, obs, expv());
            end
        end
        n_checks++;
        if (accepts != 5) begin
            n_fail++; $display("FAIL hold_valid_count: accepts=%0d want 5", accepts);
        end
    endtask

    task automatic test_abort_final();
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (obs !== 7'b000_0001) begin
            n_fail++; $display("FAIL abort_final: got %b want %b", obs, 7'b000_0001);
        end
    endtask

    task automatic test_random();
        bit c, v, d, e, a;
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            c = ($urandom_range(99) == 0);
            v = ($urandom_range(3) != 0);
            e = ($urandom_range(3) != 0);
            a = ($urandom_range(49) == 0);
            d = $urandom_range(1);
            step(c, v, $urandom_range(7), $urandom_range(3), d, e, a);
            n_checks++;
            if (obs !== expv()) begin
                n_fail++; $display("FAIL random cyc %0d: got %b want %b", i, obs, expv());
            end
        end
    endtask

    initial begin
        clr = 1'b1; cmd_valid = 1'b0; cmd_term = '0; cmd_laps = '0;
        cmd_down = 1'b0; cnt_en = 1'b0; abort = 1'b0;
        test_reset();
        test_mod6_up();
        test_mod6_down_toggle();
        test_abort();
        test_term0();
        test_term7();
        test_hold_valid();
        test_abort_final();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
